alu_uop_decode_pipe: RTL

//  Decodes RV32I OP / OP-IMM fields into ALU datapath control codes and uop-class flags for LANES issue lanes.

---
 rtl/alu_uop_decode_pipe_pkg.sv | 34 +++
 rtl/alu_uop_decode_pipe_lane_decode.sv | 42 ++++
 rtl/alu_uop_decode_pipe.sv | 115 +++++++++++
 3 files changed

// File: rtl/alu_uop_decode_pipe_pkg.sv
// alu_uop_decode_pipe_pkg: shared opcode, control-code and class encodings for the ALU uop decoder
package alu_uop_decode_pipe_pkg;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [3:0] CTRL_NONE = 4'd0;
    localparam logic [3:0] CTRL_ADD  = 4'd1;
    localparam logic [3:0] CTRL_SUB  = 4'd2;
    localparam logic [3:0] CTRL_AND  = 4'd3;
    localparam logic [3:0] CTRL_OR   = 4'd4;
    localparam logic [3:0] CTRL_XOR  = 4'd5;
    localparam logic [3:0] CTRL_SLL  = 4'd6;
    localparam logic [3:0] CTRL_SRL  = 4'd7;
    localparam logic [3:0] CTRL_SRA  = 4'd8;
    localparam logic [3:0] CTRL_SLT  = 4'd9;
    localparam logic [3:0] CTRL_SLTU = 4'd10;
    localparam int CLS_ADD   = 0;
    localparam int CLS_LOGIC = 1;
    localparam int CLS_SHIFT = 2;
    localparam int CLS_CMP   = 3;
    localparam int EV_ILLEG  = 4;
    localparam int N_EV      = 5;
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} skid_state_t;
    function automatic logic [3:0] ctrl_class(input logic [3:0] code);
        logic [3:0] c;
        c = '0;
        c[CLS_ADD]   = code inside {CTRL_ADD, CTRL_SUB};
        c[CLS_LOGIC] = code inside {CTRL_AND, CTRL_OR, CTRL_XOR};
        c[CLS_SHIFT] = code inside {CTRL_SLL, CTRL_SRL, CTRL_SRA};
        c[CLS_CMP]   = code inside {CTRL_SLT, CTRL_SLTU};
        return c;
    endfunction
endpackage

// File: rtl/alu_uop_decode_pipe_lane_decode.sv
// alu_lane_decode: combinational decode of one RV32I OP/OP-IMM lane into ALU control and class
module alu_lane_decode
    import alu_uop_decode_pipe_pkg::*;
#(
    parameter int CTRL_W = 4
) (
    input  logic              lvalid,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    output logic [CTRL_W-1:0] ctrl,
    output logic [3:0]        cls,
    output logic              illeg,
    output logic              vld
);
    logic       is_op, is_imm, f7z, f7a, f7ok;
    logic [3:0] code;
    assign is_op  = opcode == OPC_OP;
    assign is_imm = opcode == OPC_OP_IMM;
    assign f7z    = funct7 == F7_ZERO;
    assign f7a    = funct7 == F7_ALT;
    // Immediate forms carry imm[11:5] in funct7, so only the shifts constrain it
    assign f7ok   = is_imm || f7z;
    always_comb begin
        code = CTRL_NONE;
        if (is_op || is_imm)
            case (funct3)
                3'd0:    code = f7ok ? CTRL_ADD : (is_op && f7a) ? CTRL_SUB : CTRL_NONE;
                3'd1:    code = f7z ? CTRL_SLL : CTRL_NONE;
                3'd2:    code = f7ok ? CTRL_SLT : CTRL_NONE;
                3'd3:    code = f7ok ? CTRL_SLTU : CTRL_NONE;
                3'd4:    code = f7ok ? CTRL_XOR : CTRL_NONE;
                3'd5:    code = f7z ? CTRL_SRL : f7a ? CTRL_SRA : CTRL_NONE;
                3'd6:    code = f7ok ? CTRL_OR : CTRL_NONE;
                default: code = f7ok ? CTRL_AND : CTRL_NONE;
            endcase
    end
    assign vld   = lvalid && code != CTRL_NONE;
    assign illeg = lvalid && code == CTRL_NONE;
    assign ctrl  = vld ? CTRL_W'(code) : '0;
    assign cls   = vld ? ctrl_class(code) : '0;
endmodule

// File: rtl/alu_uop_decode_pipe.sv
// alu_uop_decode_pipe: multi-lane ALU uop decode behind a 2-entry skid buffer with saturating class counters
module alu_uop_decode_pipe
    import alu_uop_decode_pipe_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lvalid,
    input  logic [7*LANES-1:0]      in_opcode,
    input  logic [3*LANES-1:0]      in_funct3,
    input  logic [7*LANES-1:0]      in_funct7,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lvalid,
    output logic [CTRL_W*LANES-1:0] out_ctrl,
    output logic [4*LANES-1:0]      out_class,
    output logic [LANES-1:0]        out_illeg,
    output logic [CNT_W-1:0]        cnt_add,
    output logic [CNT_W-1:0]        cnt_logic,
    output logic [CNT_W-1:0]        cnt_shift,
    output logic [CNT_W-1:0]        cnt_cmp,
    output logic [CNT_W-1:0]        cnt_illeg
);
    localparam int EW = LANES * (CTRL_W + 6);
    localparam int CW = $clog2(LANES + 1);
    localparam int SW = CNT_W + CW;

    logic [LANES-1:0]        dec_vld, dec_illeg;
    logic [CTRL_W*LANES-1:0] dec_ctrl;
    logic [4*LANES-1:0]      dec_cls;
    logic [N_EV-1:0]         ev [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        alu_lane_decode #(.CTRL_W(CTRL_W)) u_dec (
            .lvalid (in_lvalid[i]),
            .opcode (in_opcode[7*i +: 7]),
            .funct3 (in_funct3[3*i +: 3]),
            .funct7 (in_funct7[7*i +: 7]),
            .ctrl   (dec_ctrl[CTRL_W*i +: CTRL_W]),
            .cls    (dec_cls[4*i +: 4]),
            .illeg  (dec_illeg[i]),
            .vld    (dec_vld[i])
        );
        assign ev[i] = {dec_illeg[i], dec_cls[4*i +: 4]};
    end

    logic [EW-1:0] din;
    logic [EW-1:0] ent_q [2];
    skid_state_t   state_q, state_d;
    logic          push, pop, in_ready_q;

    assign din       = {dec_vld, dec_ctrl, dec_cls, dec_illeg};
    assign in_ready  = in_ready_q;
    assign out_valid = state_q != ST_EMPTY;
    assign push      = in_valid && in_ready_q;
    assign pop       = out_valid && out_ready;
    assign {out_lvalid, out_ctrl, out_class, out_illeg} = ent_q[0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: state_d = push ? ST_ONE : ST_EMPTY;
            ST_ONE:   state_d = (push && !pop) ? ST_FULL : (pop && !push) ? ST_EMPTY : ST_ONE;
            ST_FULL:  state_d = pop ? ST_ONE : ST_FULL;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // in_ready is a flop of the next occupancy so out_ready never reaches it combinationally
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            ent_q[0]   <= '0;
            ent_q[1]   <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= state_d != ST_FULL;
            if (state_q == ST_FULL && pop) ent_q[0] <= ent_q[1];
            if (push && (state_q == ST_EMPTY || pop)) ent_q[0] <= din;
            if (push && state_q == ST_ONE && !pop) ent_q[1] <= din;
        end
    end

    logic [CW-1:0]    n_ev  [N_EV];
    logic [SW-1:0]    sum   [N_EV];
    logic [CNT_W-1:0] cnt_d [N_EV];
    logic [CNT_W-1:0] cnt_q [N_EV];

    always_comb begin
        for (int k = 0; k < N_EV; k++) begin
            n_ev[k] = '0;
            for (int l = 0; l < LANES; l++) n_ev[k] = n_ev[k] + CW'(ev[l][k]);
            sum[k]   = SW'(cnt_q[k]) + SW'(n_ev[k]);
            cnt_d[k] = |sum[k][SW-1:CNT_W] ? {CNT_W{1'b1}} : sum[k][CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_EV; k++)
            if (reset) cnt_q[k] <= '0;
            else if (push) cnt_q[k] <= cnt_d[k];
    end

    assign cnt_add   = cnt_q[CLS_ADD];
    assign cnt_logic = cnt_q[CLS_LOGIC];
    assign cnt_shift = cnt_q[CLS_SHIFT];
    assign cnt_cmp   = cnt_q[CLS_CMP];
    assign cnt_illeg = cnt_q[EV_ILLEG];
endmodule
